// File: rtl/scl_pulse_driver.sv
// Pad output driver enforcing a programmable minimum high/low time per level.
// Optional SCL_PULSE_DRIVER_STAT_EN adds a saturating 16-bit edge_count output.
//
// state | meaning
// DIS   | driver disabled, pad high-Z, no requests accepted
// IDLE  | driving pad_out, ready for any level request
// HOLD  | new level held until cnt reaches 0
module scl_pulse_driver #(
  parameter int   HOLD_W      = 8,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              drv_en,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic              in_valid,
  input  logic              in_level,
  output logic              in_ready,
  output logic              pad_out,
  output logic              pad_oeb,
  output logic              busy
`ifdef SCL_PULSE_DRIVER_STAT_EN
  ,
  output logic [15:0]       edge_count
`endif
);

  localparam logic [1:0] ST_DIS  = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [HOLD_W-1:0] cnt;
  logic [HOLD_W-1:0] hold_eff;
  logic [HOLD_W-1:0] hold_load;
  logic              ready_int;
  logic              accept;
  logic              change;

  assign hold_eff  = (cfg_hold == '0) ? HOLD_ONE : cfg_hold;
  assign hold_load = hold_eff - HOLD_ONE;

  // Ready comes from registered state only; drv_en gates it so a request
  // presented in a disabling cycle is never seen as accepted upstream.
  assign ready_int = (state == ST_IDLE) || ((state == ST_HOLD) && (cnt == '0));
  assign in_ready  = drv_en && ready_int;
  assign accept    = in_valid && in_ready;
  assign change    = accept && (in_level != pad_out);
  assign busy      = (state == ST_HOLD);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_DIS;
      cnt     <= '0;
      pad_out <= RESET_LEVEL;
      pad_oeb <= 1'b1;
    end else if (!drv_en) begin
      state   <= ST_DIS;
      cnt     <= '0;
      pad_oeb <= 1'b1;
    end else begin
      case (state)
        ST_DIS: begin
          state   <= ST_IDLE;
          pad_oeb <= 1'b0;
        end
        ST_IDLE, ST_HOLD: begin
          if (change) begin
            pad_out <= in_level;
            cnt     <= hold_load;
            state   <= ST_HOLD;
          end else if ((state == ST_HOLD) && (cnt != '0)) begin
            cnt <= cnt - HOLD_ONE;
          end else begin
            // same-level accepts are consumed here without starting a hold
            state <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_DIS;
          cnt     <= '0;
          pad_oeb <= 1'b1;
        end
      endcase
    end
  end

`ifdef SCL_PULSE_DRIVER_STAT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      edge_count <= '0;
    end else if (change && (edge_count != 16'hFFFF)) begin
      edge_count <= edge_count + 16'd1;
    end
  end
`endif

endmodule
